// File: rtl/score_pkg.sv
// Shared glyph geometry for the score-digit encoders and readers.
// Bit index of a glyph cell is row*GLYPH_W + col, row 0 at the top.
package score_pkg;
  localparam int GLYPH_W    = 14;
  localparam int GLYPH_H    = 25;
  localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;

  typedef enum logic {WAIT_FRAME = 1'b0, ACTIVE = 1'b1} rd_state_e;

  // row*14 without a multiplier: row*16 - row*2
  function automatic logic [8:0] glyph_idx(input logic [4:0] row, input logic [3:0] col);
    logic [8:0] r;
    r = {4'b0, row};
    return (r << 4) - (r << 1) + {5'b0, col};
  endfunction
endpackage

// File: rtl/frame_edge_sync.sv
// Brings an asynchronous frame strobe into the pixel clock domain and
// emits a single-cycle pulse on each rising edge.
module frame_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);
  logic [2:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[1:0], async_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/score_glyph_reader.sv
// Per-digit glyph reader: snapshots the encoder bitmap once per frame and
// answers "is this scan pixel glyph foreground" with a fixed 2-cycle latency.
module score_glyph_reader
  import score_pkg::*;
#(
  parameter logic [9:0] ORIGIN_X    = 10'd0,
  parameter logic [9:0] ORIGIN_Y    = 10'd0,
  parameter int         SCALE_SHIFT = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic [GLYPH_BITS-1:0] glyph_bits,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  draw_valid,
  output logic                  pixel_on,
  output logic                  pixel_valid,
  output logic [7:0]            snap_count
);
  localparam logic signed [10:0] WIN_W = 11'(GLYPH_W << SCALE_SHIFT);
  localparam logic signed [10:0] WIN_H = 11'(GLYPH_H << SCALE_SHIFT);

  logic                  frame_rise;
  rd_state_e             state_q;
  logic [GLYPH_BITS-1:0] snap_q;
  logic [7:0]            snap_cnt_q;

  frame_edge_sync u_sync (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .async_i(frame_clk),
    .rise_o (frame_rise)
  );

  // Snapshot is only ever loaded on a frame edge, so a frame never tears.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= WAIT_FRAME;
      snap_q     <= '0;
      snap_cnt_q <= '0;
    end else begin
      if (frame_rise) begin
        snap_q     <= glyph_bits;
        snap_cnt_q <= snap_cnt_q + 8'd1;
      end
      case (state_q)
        WAIT_FRAME: if (frame_rise) state_q <= ACTIVE;
        ACTIVE:     state_q <= ACTIVE;
        default:    state_q <= WAIT_FRAME;
      endcase
    end
  end

  // Stage 1: window test and cell coordinates
  logic signed [10:0] dx, dy;
  logic               in_win_d;
  logic [3:0]         col_d;
  logic [4:0]         row_d;

  always_comb begin
    dx       = $signed({1'b0, DrawX}) - $signed({1'b0, ORIGIN_X});
    dy       = $signed({1'b0, DrawY}) - $signed({1'b0, ORIGIN_Y});
    in_win_d = !dx[10] && (dx < WIN_W) && !dy[10] && (dy < WIN_H);
    // Out-of-window coordinates collapse to cell 0 so the lookup stays in range.
    col_d    = in_win_d ? 4'(unsigned'(dx) >> SCALE_SHIFT) : 4'd0;
    row_d    = in_win_d ? 5'(unsigned'(dy) >> SCALE_SHIFT) : 5'd0;
  end

  logic [1:0] vld_pipe_q;
  logic       in_win_q;
  logic [3:0] col_q;
  logic [4:0] row_q;
  logic       pixel_on_q;

  // Stage 2: bitmap lookup
  logic [8:0] idx;
  logic       hit;

  always_comb begin
    idx = glyph_idx(row_q, col_q);
    hit = (idx < 9'(GLYPH_BITS)) ? snap_q[idx] : 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      vld_pipe_q <= '0;
      in_win_q   <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      pixel_on_q <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], draw_valid};
      in_win_q   <= in_win_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pixel_on_q <= vld_pipe_q[0] & in_win_q & (state_q == ACTIVE) & hit;
    end
  end

  assign pixel_on    = pixel_on_q;
  assign pixel_valid = vld_pipe_q[1];
  assign snap_count  = snap_cnt_q;
endmodule

// File: tb/tb_score_glyph_reader.sv
// Scoreboard bench: two readers at origin (100,50), scale 1x and 2x, share stimulus.
module tb_score_glyph_reader;
  logic         Clk = 1'b0, Reset = 1'b0, frame_clk = 1'b0, draw_valid = 1'b0;
  logic [349:0] glyph_bits = '0;
  logic [9:0]   DrawX = '0, DrawY = '0;
  logic         po_a, pv_a, po_b, pv_b;
  logic [7:0]   sc_a, sc_b;
  logic [349:0] d1, d0, d8, b77;

  int tests = 0, fails = 0, cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {int cyc; bit ca; bit ea; bit cb; bit eb; string nm;} exp_t;
  exp_t q[$];
  exp_t me;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  score_glyph_reader #(.ORIGIN_X(10'd100), .ORIGIN_Y(10'd50), .SCALE_SHIFT(0)) dut_a (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .glyph_bits(glyph_bits),
    .DrawX(DrawX), .DrawY(DrawY), .draw_valid(draw_valid),
    .pixel_on(po_a), .pixel_valid(pv_a), .snap_count(sc_a));

  score_glyph_reader #(.ORIGIN_X(10'd100), .ORIGIN_Y(10'd50), .SCALE_SHIFT(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .glyph_bits(glyph_bits),
    .DrawX(DrawX), .DrawY(DrawY), .draw_valid(draw_valid),
    .pixel_on(po_b), .pixel_valid(pv_b), .snap_count(sc_b));

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per presented output
  always @(negedge Clk) if (mon_en) begin
    if (pv_a === 1'b1) begin
      if (q.size() == 0) chk("spurious_valid", pv_a, 8'd0);
      else begin
        me = q.pop_front();
        chk({me.nm, "_latency"}, 8'(cyc - me.cyc), 8'd2);
        if (me.ca) chk({me.nm, "_a"}, po_a, me.ea);
        if (me.cb) chk({me.nm, "_b"}, po_b, me.eb);
        chk({me.nm, "_valid_b"}, pv_b, 8'd1);
      end
    end else begin
      chk("idle_on_a", po_a, 8'd0);
    end
  end

  task automatic px(input int x, input int y, input bit ca, input bit ea,
                    input bit cb, input bit eb, input string nm);
    @(posedge Clk); #1;
    DrawX = 10'(x); DrawY = 10'(y); draw_valid = 1'b1;
    q.push_back('{cyc, ca, ea, cb, eb, nm});
  endtask

  task automatic px_invalid(input int x, input int y);
    @(posedge Clk); #1;
    DrawX = 10'(x); DrawY = 10'(y); draw_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    @(posedge Clk); #1 draw_valid = 1'b0;
    repeat (n - 1) @(posedge Clk);
  endtask

  task automatic frame_pulse();
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
  endtask

  task automatic snap(input string nm, input logic [7:0] exp);
    @(negedge Clk);
    chk({nm, "_a"}, sc_a, exp);
    chk({nm, "_b"}, sc_b, exp);
  endtask

  initial begin
    d1 = '0; d1[0] = 1'b1; d1[77] = 1'b1; d1[78] = 1'b1; d1[84] = 1'b1;
    d1[90] = 1'b1; d1[91] = 1'b1; d1[92] = 1'b1; d1[349] = 1'b1;
    d0 = '0; d0[140] = 1'b1; d0[15] = 1'b1;
    d8 = d0; d8[141] = 1'b1;
    b77 = '0; b77[77] = 1'b1;
    glyph_bits = d1;

    // reset held 3 cycles
    @(posedge Clk); #1 mon_en = 1'b1;
    @(negedge Clk);
    chk("rst_pixel_on", po_a, 8'd0);
    chk("rst_pixel_valid", pv_a, 8'd0);
    chk("rst_snap", sc_a, 8'd0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;

    // no frame yet: valid tracks, pixel_on forced low
    px(107, 55, 1, 0, 1, 0, "wait_77");
    px(107, 55, 1, 0, 1, 0, "wait_77b");
    px(100, 50, 1, 0, 1, 0, "wait_0");
    idle(4);
    snap("wait_snap", 8'd0);

    frame_pulse();
    snap("d1_snap", 8'd1);
    px(107, 55, 1, 1, 0, 0, "d1_bit77");
    px(106, 55, 1, 0, 0, 0, "d1_bit76");
    px_invalid(107, 55);
    px(100, 50, 1, 1, 0, 0, "d1_bit0");
    px(100, 56, 1, 1, 0, 0, "d1_bit84");
    px(113, 74, 1, 1, 0, 0, "d1_bit349");
    px(99, 56, 1, 0, 0, 0, "edge_x99");
    px(114, 55, 1, 0, 0, 0, "edge_x114");
    px(100, 49, 1, 0, 0, 0, "edge_y49");
    px(113, 75, 1, 0, 0, 0, "edge_y75");
    idle(4);

    // 2x scale: cell 77 (row 5, col 7) covers x 114..115, y 60..61
    glyph_bits = b77;
    frame_pulse();
    snap("b77_snap", 8'd2);
    px(114, 60, 1, 0, 1, 1, "s2_114_60");
    px(115, 60, 0, 0, 1, 1, "s2_115_60");
    px(114, 61, 0, 0, 1, 1, "s2_114_61");
    px(115, 61, 0, 0, 1, 1, "s2_115_61");
    px(116, 60, 0, 0, 1, 0, "s2_116_60");
    px(113, 60, 0, 0, 1, 0, "s2_113_60");
    px(107, 55, 1, 1, 0, 0, "b77_a");
    idle(4);

    // tearing: bitmap changes mid-frame, snapshot holds
    glyph_bits = d0;
    frame_pulse();
    glyph_bits = d8;
    idle(6);
    px(101, 60, 1, 0, 0, 0, "tear_old141");
    px(100, 60, 1, 1, 0, 0, "tear_old140");
    idle(4);
    snap("tear_snap", 8'd3);
    frame_pulse();
    px(101, 60, 1, 1, 0, 0, "tear_new141");
    idle(4);
    snap("tear_snap2", 8'd4);

    // mid-frame reset
    @(posedge Clk); #1 Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    snap("mrst_snap", 8'd0);
    px(101, 60, 1, 0, 1, 0, "mrst_wait");
    idle(4);
    frame_pulse();
    snap("mrst_snap2", 8'd1);
    px(101, 60, 1, 1, 0, 0, "mrst_resume");
    idle(4);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
    chk("drain_pending", 8'(q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
